step_clock_gen: RTL and testbench
=================================

STEP_CLOCK_GEN -- requirements
Module: step_clock_gen

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable CLK cycles required to accept a button level change.
REQ-002 SHALL have parameter PULSE_CYCLES, default 5000000, meaning the CPUCLK high time of one single-step pulse in CLK cycles (>=1).
REQ-003 SHALL have parameter RUN_HALF, default 25000000, meaning the CPUCLK half-period in free-run mode in CLK cycles (>=1).
REQ-004 SHALL have port CLK  input  1  the 100 MHz board clock; the only clock in the block.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port Button  input  1  raw, bouncing, asynchronous step push-button, 1 = pressed.
REQ-007 SHALL have port RunMode  input  1  raw, asynchronous slide switch, 1 = free-run, 0 = single-step.
REQ-008 SHALL have port CPUCLK  output  1  generated, registered clock driving the multi-cycle CPU.
REQ-009 SHALL have port StepCount  output  16  number of CPUCLK rising edges produced since reset.
REQ-010 SHALL have port Busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL pass Button and RunMode each through a two-flop synchronizer before any other use.
REQ-012 SHALL hold a debounced button level; when the synchronized Button differs from it for DEBOUNCE_CYCLES consecutive cycles, the level SHALL take the new value and the counter SHALL clear.
REQ-013 SHALL clear the debounce counter on any cycle where the synchronized Button equals the debounced level (a single-cycle glitch restarts the count).
REQ-014 SHALL generate a one-cycle press event on each 0->1 transition of the debounced level; release events are not generated.
REQ-015 SHALL implement FSM states IDLE, STEP_HIGH, RUN_HIGH, RUN_LOW with a shared phase counter.
REQ-016 IDLE: CPUCLK=0; if synchronized RunMode=1 go to RUN_HIGH; else if press event go to STEP_HIGH; RunMode takes priority when both occur in the same cycle.
REQ-017 STEP_HIGH: CPUCLK=1 for exactly PULSE_CYCLES cycles, then IDLE; press events and RunMode changes during STEP_HIGH are ignored (not queued).
REQ-018 RUN_HIGH: CPUCLK=1 for exactly RUN_HALF cycles, then RUN_LOW.
REQ-019 RUN_LOW: CPUCLK=0 for exactly RUN_HALF cycles, then RUN_HIGH if synchronized RunMode=1, else IDLE; a RunMode drop never truncates a half-period.
REQ-020 Press events SHALL be ignored in RUN_HIGH and RUN_LOW.
REQ-021 CPUCLK SHALL be a flop output, asserted in the first cycle the FSM is in STEP_HIGH or RUN_HIGH (one cycle after the press event or RunMode sample).
REQ-022 StepCount SHALL increment by 1 on every entry to STEP_HIGH or RUN_HIGH, coincident with CPUCLK rising, and wrap from 0xFFFF to 0x0000.
REQ-023 Busy SHALL be registered and equal (state != IDLE).

Reset
REQ-024 Reset asserted SHALL immediately force state IDLE, CPUCLK=0, StepCount=0, Busy=0, debounced level=0, debounce and phase counters=0, synchronizer flops=0.
REQ-025 Reset asserted mid-pulse SHALL end the pulse at once; after release a button held throughout SHALL produce no pulse until released and pressed again after debouncing completes.
REQ-026 Reset deassertion SHALL be synchronized to CLK by the top level; the block samples it only asynchronously on assertion.

Verification (DEBOUNCE_CYCLES=4, PULSE_CYCLES=3, RUN_HALF=2)
REQ-027 Reset, Button held 1 from cycle 0 -> CPUCLK rises at cycle 2+4+1=7 (+/-1 for sync phase), stays high 3 cycles, StepCount=1, Busy high 3 cycles.
REQ-028 Button toggled 1/0 every 2 cycles for 40 cycles, then held 0 -> no CPUCLK pulse, StepCount=0.
REQ-029 Button pressed and released cleanly 3 times, 20 cycles apart -> exactly 3 pulses of 3 cycles, StepCount=3.
REQ-030 RunMode=1 for 20 cycles then 0 mid-RUN_HIGH -> CPUCLK square wave 2 high/2 low, last half-periods complete, FSM returns to IDLE with CPUCLK=0, StepCount equals rising edges counted.
REQ-031 Preload StepCount to 0xFFFF via 65535 run edges (or force), one more press -> StepCount=0x0000.
REQ-032 Reset pulsed during STEP_HIGH with Button still held -> CPUCLK=0 and StepCount=0 immediately; no pulse until Button released and re-pressed.

Source files
------------

// File: rtl/step_clock_gen.sv
// Single-step / free-run clock generator for a multi-cycle CPU.
// Synchronizes and debounces the step button, then shapes CPUCLK with a small FSM.
`timescale 1ns/1ps
module step_clock_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PULSE_CYCLES    = 5000000,
  parameter int RUN_HALF        = 25000000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Button,
  input  logic        RunMode,
  output logic        CPUCLK,
  output logic [15:0] StepCount,
  output logic        Busy
);

  // state     | meaning
  // IDLE      | CPUCLK low, waiting for a press event or RunMode
  // STEP_HIGH | single-step pulse, CPUCLK high for PULSE_CYCLES
  // RUN_HIGH  | free-run high half-period
  // RUN_LOW   | free-run low half-period
  typedef enum logic [1:0] {IDLE, STEP_HIGH, RUN_HIGH, RUN_LOW} state_t;

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PH_MAX = (PULSE_CYCLES > RUN_HALF) ? PULSE_CYCLES : RUN_HALF;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PH_W-1:0] PULSE_LOAD = PH_W'(PULSE_CYCLES - 1);
  localparam logic [PH_W-1:0] HALF_LOAD  = PH_W'(RUN_HALF - 1);

  logic            btn_s1, btn_s2, run_s1, run_s2;
  logic            fill1, fill2;
  logic            armed;
  logic            db_level, db_prev;
  logic [DB_W-1:0] db_cnt;
  logic            press;

  state_t          state, state_nx;
  logic [PH_W-1:0] phase, phase_nx;
  logic            clk_nx, busy_nx, count_en;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      run_s1 <= 1'b0;
      run_s2 <= 1'b0;
      fill1  <= 1'b0;
      fill2  <= 1'b0;
    end else begin
      btn_s1 <= Button;
      btn_s2 <= btn_s1;
      run_s1 <= RunMode;
      run_s2 <= run_s1;
      fill1  <= 1'b1;
      fill2  <= fill1;
    end
  end

  // fill2 marks when btn_s2 carries a real sample rather than the reset zero;
  // presses stay disarmed until the button has actually been seen released,
  // so a button held across reset cannot fire a pulse.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
      armed    <= 1'b0;
    end else begin
      db_prev <= db_level;
      if (fill2 && !btn_s2)
        armed <= 1'b1;
      if (btn_s2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= btn_s2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press = db_level & ~db_prev & armed;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      phase     <= '0;
      CPUCLK    <= 1'b0;
      Busy      <= 1'b0;
      StepCount <= 16'h0000;
    end else begin
      state  <= state_nx;
      phase  <= phase_nx;
      CPUCLK <= clk_nx;
      Busy   <= busy_nx;
      if (count_en)
        StepCount <= StepCount + 16'h0001;
    end
  end

  // phase is a down-counter loaded with (length-1) on entry; zero is terminal
  always_comb begin
    state_nx = state;
    phase_nx = phase;
    case (state)
      IDLE: begin
        if (run_s2) begin
          state_nx = RUN_HIGH;
          phase_nx = HALF_LOAD;
        end else if (press) begin
          state_nx = STEP_HIGH;
          phase_nx = PULSE_LOAD;
        end
      end
      STEP_HIGH: begin
        if (phase == '0) state_nx = IDLE;
        else             phase_nx = phase - 1'b1;
      end
      RUN_HIGH: begin
        if (phase == '0) begin
          state_nx = RUN_LOW;
          phase_nx = HALF_LOAD;
        end else begin
          phase_nx = phase - 1'b1;
        end
      end
      RUN_LOW: begin
        if (phase == '0) begin
          if (run_s2) begin
            state_nx = RUN_HIGH;
            phase_nx = HALF_LOAD;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          phase_nx = phase - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    clk_nx   = (state_nx == STEP_HIGH) || (state_nx == RUN_HIGH);
    busy_nx  = (state_nx != IDLE);
    count_en = clk_nx && (state_nx != state);
  end

endmodule

// File: tb/tb_step_clock_gen.sv
// Scoreboard bench for step_clock_gen: stimulus pushes expected pulses,
// a monitor measures every CPUCLK pulse and pops/compares.
`timescale 1ns/1ps
module tb_step_clock_gen;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        Button = 1'b0;
  logic        RunMode = 1'b0;
  logic        CPUCLK;
  logic [15:0] StepCount;
  logic        Busy;

  typedef struct {
    logic [15:0] cnt;
    int          width;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  step_clock_gen #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(3), .RUN_HALF(2)) dut (
    .CLK(CLK), .Reset(Reset), .Button(Button), .RunMode(RunMode),
    .CPUCLK(CPUCLK), .StepCount(StepCount), .Busy(Busy)
  );

  initial forever #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] c, input int w);
    exp_t e;
    e.cnt = c;
    e.width = w;
    sb.push_back(e);
  endtask

  // Monitor: measure each CPUCLK high run at negedges, pop expectation on its fall.
  initial begin
    bit          in_pulse = 0;
    logic [15:0] rise_cnt = '0;
    int          width = 0;
    exp_t        e;
    forever begin
      @(negedge CLK);
      if (Reset) begin
        in_pulse = 0;
      end else if (CPUCLK) begin
        if (!in_pulse) begin
          in_pulse = 1;
          rise_cnt = StepCount;
          width = 1;
        end else begin
          width++;
        end
      end else if (in_pulse) begin
        in_pulse = 0;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pulse: count %0h width %0d, none expected", rise_cnt, width);
        end else begin
          e = sb.pop_front();
          check("pulse_count", 32'(rise_cnt), 32'(e.cnt));
          check("pulse_width", width, e.width);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Reset with inputs low; released on a negedge so the next posedge is "edge 0".
  task automatic do_reset();
    Button = 1'b0;
    RunMode = 1'b0;
    @(negedge CLK);
    Reset = 1'b1;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
  endtask

  task automatic press_release();
    Button = 1'b1;
    cycles(8);
    Button = 1'b0;
    cycles(12);
  endtask

  initial begin
    int k;
    // reset state
    do_reset();
    #1;
    check("reset_cpuclk", 32'(CPUCLK), 0);
    check("reset_count", 32'(StepCount), 0);
    check("reset_busy", 32'(Busy), 0);

    // held button: rise expected 7 edges after edge 0
    cycles(1);
    Button = 1'b1;
    push(16'h0001, 3);
    k = 99;
    for (int i = 1; i <= 12; i++) begin
      cycles(1);
      if (CPUCLK) begin
        k = i;
        break;
      end
    end
    tests++;
    if (!(k >= 6 && k <= 8)) begin
      fails++;
      $display("FAIL held_rise_edge: got %0d expected 7 +/-1", k);
    end
    check("held_busy_high", 32'(Busy), 1);
    cycles(3);
    check("held_cpuclk_done", 32'(CPUCLK), 0);
    check("held_busy_done", 32'(Busy), 0);
    Button = 1'b0;
    cycles(12);
    check("held_count", 32'(StepCount), 1);

    // bouncing button never debounces
    do_reset();
    for (int i = 0; i < 20; i++) begin
      Button = 1'b1;
      cycles(2);
      Button = 1'b0;
      cycles(2);
    end
    cycles(20);
    check("bounce_count", 32'(StepCount), 0);
    check("bounce_cpuclk", 32'(CPUCLK), 0);

    // three clean presses
    do_reset();
    cycles(1);
    for (int i = 1; i <= 3; i++) begin
      push(16'(i), 3);
      press_release();
    end
    check("three_count", 32'(StepCount), 3);

    // free-run: RunMode up after edge 0, down after edge 20 -> rises at edges 3,7,11,15,19
    do_reset();
    cycles(1);
    RunMode = 1'b1;
    for (int i = 1; i <= 5; i++) push(16'(i), 2);
    cycles(20);
    RunMode = 1'b0;
    cycles(20);
    check("run_count", 32'(StepCount), 5);
    check("run_cpuclk_idle", 32'(CPUCLK), 0);
    check("run_busy_idle", 32'(Busy), 0);

    // wrap 0xFFFF -> 0x0000
    @(negedge CLK);
    force dut.StepCount = 16'hFFFF;
    @(negedge CLK);
    release dut.StepCount;
    cycles(1);
    push(16'h0000, 3);
    press_release();
    check("wrap_count", 32'(StepCount), 0);

    // reset mid-pulse with button held
    do_reset();
    cycles(1);
    Button = 1'b1;
    k = 0;
    for (int i = 1; i <= 15; i++) begin
      cycles(1);
      if (CPUCLK) begin
        k = 1;
        break;
      end
    end
    check("midreset_pulse_seen", k, 1);
    #2;
    Reset = 1'b1;
    #1;
    check("midreset_cpuclk", 32'(CPUCLK), 0);
    check("midreset_count", 32'(StepCount), 0);
    check("midreset_busy", 32'(Busy), 0);
    @(negedge CLK);
    Reset = 1'b0;
    cycles(30);
    check("held_after_reset_count", 32'(StepCount), 0);
    Button = 1'b0;
    cycles(12);
    push(16'h0001, 3);
    press_release();
    check("repress_count", 32'(StepCount), 1);

    cycles(20);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
